color_sample_controller: RTL and testbench



---
 rtl/color_sample_controller.sv | 204 ++++++++++++++++++++
 tb/tb_color_sample_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/color_sample_controller.sv
// color_sample_controller
// Qualifies an observation of the edge and corner color sensors after a setup move.
// It waits for the mechanism to settle, then takes spaced samples of both colors.
// An observation is accepted only when every sample agrees and is a legal color.
// Otherwise the settle-and-sample attempt is repeated a bounded number of times.

module color_sample_controller #(
    parameter int SETTLE_CYCLES   = 12500,
    parameter int SAMPLE_INTERVAL = 25000,
    parameter int NUM_SAMPLES     = 4,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] edge_color,
    input  logic [2:0] corner_color,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] edge_out,
    output logic [2:0] corner_out,
    output logic [1:0] retry_count
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int IW = $clog2(SAMPLE_INTERVAL) + 1;
    localparam int MW = $clog2(NUM_SAMPLES) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [IW-1:0] INTV_LOAD   = IW'(SAMPLE_INTERVAL - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(NUM_SAMPLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE,
        FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settleCnt_q, settleCnt_d;
    logic [IW-1:0]   intvCnt_q, intvCnt_d;
    logic [MW-1:0]   matchCnt_q, matchCnt_d;
    logic [RW-1:0]   retriesUsed_q, retriesUsed_d;
    logic [1:0]      retryCount_q, retryCount_d;
    logic [2:0]      refEdge_q, refEdge_d;
    logic [2:0]      refCorner_q, refCorner_d;
    logic [2:0]      edgeOut_q, edgeOut_d;
    logic [2:0]      cornerOut_q, cornerOut_d;
    logic            error_q, error_d;

    logic            captureNow;
    logic            sampleValid;
    logic            sampleMatch;
    logic            attemptFail;
    logic            lastMatch;
    logic            canRetry;

    // Decode the current capture: the first capture of an attempt only needs to be
    // a legal color, later ones must also equal the reference pair.
    always_comb begin
        captureNow  = (state_q == SAMPLE) && (intvCnt_q == '0);
        sampleValid = (edge_color < 3'd6) && (corner_color < 3'd6);
        sampleMatch = (matchCnt_q == '0) ||
                      ((edge_color == refEdge_q) && (corner_color == refCorner_q));
        attemptFail = captureNow && !(sampleValid && sampleMatch);
        lastMatch   = captureNow && !attemptFail && (matchCnt_q == MATCH_LAST);
        canRetry    = (retriesUsed_q < RETRY_LIMIT);
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SETTLE;
            end
            SETTLE: begin
                if (settleCnt_q <= SW'(1)) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (attemptFail) begin
                    state_d = canRetry ? SETTLE : FAIL;
                end else if (lastMatch) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the counters, reference pair, results and error flag.
    always_comb begin
        settleCnt_d   = settleCnt_q;
        intvCnt_d     = intvCnt_q;
        matchCnt_d    = matchCnt_q;
        retriesUsed_d = retriesUsed_q;
        retryCount_d  = retryCount_q;
        refEdge_d     = refEdge_q;
        refCorner_d   = refCorner_q;
        edgeOut_d     = edgeOut_q;
        cornerOut_d   = cornerOut_q;
        error_d       = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    settleCnt_d   = SETTLE_LOAD;
                    error_d       = 1'b0;
                    retryCount_d  = 2'd0;
                    retriesUsed_d = '0;
                end
            end
            SETTLE: begin
                settleCnt_d = settleCnt_q - SW'(1);
                if (settleCnt_q <= SW'(1)) begin
                    intvCnt_d  = '0;
                    matchCnt_d = '0;
                end
            end
            SAMPLE: begin
                if (intvCnt_q != '0) begin
                    intvCnt_d = intvCnt_q - IW'(1);
                end else begin
                    intvCnt_d = INTV_LOAD;
                    if (attemptFail) begin
                        if (canRetry) begin
                            retriesUsed_d = retriesUsed_q + RW'(1);
                            if (retryCount_q != 2'd3) retryCount_d = retryCount_q + 2'd1;
                            settleCnt_d = SETTLE_LOAD;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        if (matchCnt_q == '0) begin
                            refEdge_d   = edge_color;
                            refCorner_d = corner_color;
                        end
                        matchCnt_d = matchCnt_q + MW'(1);
                        if (lastMatch) begin
                            edgeOut_d   = refEdge_q;
                            cornerOut_d = refCorner_q;
                            error_d     = 1'b0;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            settleCnt_q   <= '0;
            intvCnt_q     <= '0;
            matchCnt_q    <= '0;
            retriesUsed_q <= '0;
            retryCount_q  <= 2'd0;
            refEdge_q     <= 3'd0;
            refCorner_q   <= 3'd0;
            edgeOut_q     <= 3'd0;
            cornerOut_q   <= 3'd0;
            error_q       <= 1'b0;
        end else begin
            settleCnt_q   <= settleCnt_d;
            intvCnt_q     <= intvCnt_d;
            matchCnt_q    <= matchCnt_d;
            retriesUsed_q <= retriesUsed_d;
            retryCount_q  <= retryCount_d;
            refEdge_q     <= refEdge_d;
            refCorner_q   <= refCorner_d;
            edgeOut_q     <= edgeOut_d;
            cornerOut_q   <= cornerOut_d;
            error_q       <= error_d;
        end
    end

    // Status outputs decoded from the state and the result registers.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE) || (state_q == FAIL);
        error       = error_q;
        edge_out    = edgeOut_q;
        corner_out  = cornerOut_q;
        retry_count = retryCount_q;
    end

endmodule

// File: tb/tb_color_sample_controller.sv
// Directed testbench for color_sample_controller with short timing parameters.
// Cycle k below means "observed 1 time unit after the k-th rising edge following
// the edge that accepted start". A clean observation finishes at k = 14:
// 4 settle cycles, captures at k = 4, 7, 10, 13, then the done cycle.

module tb_color_sample_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] edge_color;
    logic [2:0] corner_color;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] edge_out;
    logic [2:0] corner_out;
    logic [1:0] retry_count;

    int errors = 0;
    int checks = 0;

    int         obsDoneAt;
    int         obsDoneCnt;
    logic [2:0] obsEdge;
    logic [2:0] obsCorner;
    logic       obsErr;
    logic [1:0] obsRetry;

    color_sample_controller #(
        .SETTLE_CYCLES  (4),
        .SAMPLE_INTERVAL(3),
        .NUM_SAMPLES    (4),
        .MAX_RETRIES    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .edge_color  (edge_color),
        .corner_color(corner_color),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .edge_out    (edge_out),
        .corner_out  (corner_out),
        .retry_count (retry_count)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulses start with the given colors; the edge that samples it is k = 0.
    task automatic beginObs(input logic [2:0] e, input logic [2:0] c);
        edge_color   = e;
        corner_color = c;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Runs a bounded window, optionally changing the edge color or pulsing start
    // before a given edge, and records the first done pulse and the outputs with it.
    task automatic runObs(input int maxCycles, input int changeAt,
                          input logic [2:0] changeEdge, input int startAt);
        obsDoneAt  = -1;
        obsDoneCnt = 0;
        obsEdge    = 3'd0;
        obsCorner  = 3'd0;
        obsErr     = 1'b0;
        obsRetry   = 2'd0;
        for (int k = 1; k <= maxCycles; k++) begin
            if (k == changeAt) edge_color = changeEdge;
            if (k == startAt) start = 1'b1;
            if (startAt > 0 && k == startAt + 1) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                obsDoneCnt++;
                if (obsDoneAt < 0) begin
                    obsDoneAt = k;
                    obsEdge   = edge_out;
                    obsCorner = corner_out;
                    obsErr    = error;
                    obsRetry  = retry_count;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        start        = 1'b0;
        edge_color   = 3'd0;
        corner_color = 3'd0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        checks++; if (edge_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_edge_out: got %0d want 0", edge_out); end
        checks++; if (corner_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_corner_out: got %0d want 0", corner_out); end
        checks++; if (retry_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_retry: got %0d want 0", retry_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        beginObs(3'd2, 3'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_after_start: got %b want 1", busy); end
        runObs(20, -1, 3'd0, -1);
        checks++; if (obsDoneAt != 14) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d want 14", obsDoneAt); end
        checks++; if (obsDoneCnt != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d want 1", obsDoneCnt); end
        checks++; if (obsEdge !== 3'd2) begin errors++; $display("[TB] FAIL basic_edge_out: got %0d want 2", obsEdge); end
        checks++; if (obsCorner !== 3'd3) begin errors++; $display("[TB] FAIL basic_corner_out: got %0d want 3", obsCorner); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("[TB] FAIL basic_error: got %b want 0", obsErr); end
        checks++; if (obsRetry !== 2'd0) begin errors++; $display("[TB] FAIL basic_retry: got %0d want 0", obsRetry); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after: got busy %b want 0", busy); end
    endtask

    // Edge changes 2 -> 4 before edge 9: the capture at k = 10 mismatches, a new
    // settle runs over k = 11..14, sampling restarts at k = 15, done at k = 25.
    task automatic test_retry();
        beginObs(3'd2, 3'd3);
        runObs(35, 9, 3'd4, -1);
        checks++; if (obsDoneAt != 25) begin errors++; $display("[TB] FAIL retry_done_cycle: got %0d want 25", obsDoneAt); end
        checks++; if (obsRetry !== 2'd1) begin errors++; $display("[TB] FAIL retry_count: got %0d want 1", obsRetry); end
        checks++; if (obsEdge !== 3'd4) begin errors++; $display("[TB] FAIL retry_edge_out: got %0d want 4", obsEdge); end
        checks++; if (obsCorner !== 3'd3) begin errors++; $display("[TB] FAIL retry_corner_out: got %0d want 3", obsCorner); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("[TB] FAIL retry_error: got %b want 0", obsErr); end
    endtask

    // Invalid edge: every attempt fails on its first capture (k = 4, 9, 14),
    // so the failure pulse appears at k = 15 after two retries.
    task automatic test_invalid();
        beginObs(3'd7, 3'd3);
        runObs(25, -1, 3'd0, -1);
        checks++; if (obsDoneAt != 15) begin errors++; $display("[TB] FAIL invalid_done_cycle: got %0d want 15", obsDoneAt); end
        checks++; if (obsDoneCnt != 1) begin errors++; $display("[TB] FAIL invalid_done_count: got %0d want 1", obsDoneCnt); end
        checks++; if (obsErr !== 1'b1) begin errors++; $display("[TB] FAIL invalid_error: got %b want 1", obsErr); end
        checks++; if (obsRetry !== 2'd2) begin errors++; $display("[TB] FAIL invalid_retry: got %0d want 2", obsRetry); end
        checks++; if (obsEdge !== 3'd4) begin errors++; $display("[TB] FAIL invalid_edge_kept: got %0d want 4", obsEdge); end
        checks++; if (obsCorner !== 3'd3) begin errors++; $display("[TB] FAIL invalid_corner_kept: got %0d want 3", obsCorner); end
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL invalid_error_held: got %b want 1", error); end
        beginObs(3'd2, 3'd3);
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL invalid_error_cleared: got %b want 0", error); end
        runObs(20, -1, 3'd0, -1);
        checks++; if (obsDoneAt != 14) begin errors++; $display("[TB] FAIL invalid_recover_cycle: got %0d want 14", obsDoneAt); end
        checks++; if (obsEdge !== 3'd2) begin errors++; $display("[TB] FAIL invalid_recover_edge: got %0d want 2", obsEdge); end
    endtask

    task automatic test_start_while_busy();
        beginObs(3'd2, 3'd3);
        runObs(40, -1, 3'd0, 5);
        checks++; if (obsDoneCnt != 1) begin errors++; $display("[TB] FAIL busy_start_done_count: got %0d want 1", obsDoneCnt); end
        checks++; if (obsDoneAt != 14) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d want 14", obsDoneAt); end
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        beginObs(3'd5, 3'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) reset = 1'b1;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
        checks++; if (edge_out !== 3'd0) begin errors++; $display("[TB] FAIL midreset_edge_out: got %0d want 0", edge_out); end
        checks++; if (corner_out !== 3'd0) begin errors++; $display("[TB] FAIL midreset_corner_out: got %0d want 0", corner_out); end
        checks++; if (retry_count !== 2'd0) begin errors++; $display("[TB] FAIL midreset_retry: got %0d want 0", retry_count); end
        reset    = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done === 1'b1) doneSeen++;
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses want 0", doneSeen); end
        beginObs(3'd2, 3'd3);
        runObs(20, -1, 3'd0, -1);
        checks++; if (obsDoneAt != 14) begin errors++; $display("[TB] FAIL midreset_fresh_cycle: got %0d want 14", obsDoneAt); end
        checks++; if (obsEdge !== 3'd2) begin errors++; $display("[TB] FAIL midreset_fresh_edge: got %0d want 2", obsEdge); end
        checks++; if (obsCorner !== 3'd3) begin errors++; $display("[TB] FAIL midreset_fresh_corner: got %0d want 3", obsCorner); end
    endtask

    // Start held high: first accept at k = 1, done at 15, IDLE at 16, next
    // accept at 17, so done pulses land at 15, 31 and 47.
    task automatic test_back_to_back();
        int   doneAt[3];
        int   nDone;
        logic busyLog[1:50];
        nDone        = 0;
        doneAt       = '{-1, -1, -1};
        edge_color   = 3'd1;
        corner_color = 3'd0;
        start        = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            busyLog[k] = busy;
            if (done === 1'b1) begin
                if (nDone < 3) doneAt[nDone] = k;
                nDone++;
            end
        end
        start = 1'b0;
        checks++; if (nDone != 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d want 3", nDone); end
        checks++; if (doneAt[0] != 15) begin errors++; $display("[TB] FAIL b2b_done0: got %0d want 15", doneAt[0]); end
        checks++; if (doneAt[1] != 31) begin errors++; $display("[TB] FAIL b2b_done1: got %0d want 31", doneAt[1]); end
        checks++; if (doneAt[2] != 47) begin errors++; $display("[TB] FAIL b2b_done2: got %0d want 47", doneAt[2]); end
        checks++; if (busyLog[16] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got busy %b want 0", busyLog[16]); end
        checks++; if (busyLog[17] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart: got busy %b want 1", busyLog[17]); end
        checks++; if (edge_out !== 3'd1) begin errors++; $display("[TB] FAIL b2b_edge_out: got %0d want 1", edge_out); end
        for (int k = 0; k < 20; k++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_idle: got busy %b want 0", busy); end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_invalid();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
